// File: rtl/bird_game_ctrl.sv
// Game sequencer for the bird column: turns key presses into flaps, paces falls,
// detects collisions, counts passed pipes and restarts the light array.
module bird_game_ctrl #(
   parameter int unsigned ROWS       = 8,
   parameter int unsigned FALL_TICKS = 4,
   parameter int unsigned SCORE_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key,
   input  logic               tick,
   input  logic [ROWS-1:0]    bird_rows,
   input  logic [ROWS-1:0]    pipe_rows,
   input  logic               pipe_pass,
   output logic               flap,
   output logic               fall,
   output logic               restart,
   output logic               playing,
   output logic               game_over,
   output logic [SCORE_W-1:0] score
);

   localparam int unsigned CNT_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FALL_TICKS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t             state, state_n;
   logic               key_q;
   logic [CNT_W-1:0]   fall_cnt, fall_cnt_n;
   logic [SCORE_W-1:0] score_n;
   logic               flap_n, fall_n, restart_n;
   logic               press, collision;

   assign press     = key & ~key_q;
   assign collision = (|(bird_rows & pipe_rows)) | (bird_rows == '0);

   // State and registered outputs; key_q keeps tracking key during reset
   always_ff @(posedge clk) begin
      key_q <= key;
      if (reset) begin
         state     <= IDLE;
         fall_cnt  <= '0;
         score     <= '0;
         flap      <= 1'b0;
         fall      <= 1'b0;
         restart   <= 1'b0;
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         fall_cnt  <= fall_cnt_n;
         score     <= score_n;
         flap      <= flap_n;
         fall      <= fall_n;
         restart   <= restart_n;
         playing   <= (state_n == PLAY);
         game_over <= (state_n == OVER);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n    = state;
      fall_cnt_n = fall_cnt;
      score_n    = score;
      flap_n     = 1'b0;
      fall_n     = 1'b0;
      restart_n  = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               state_n    = PLAY;
               score_n    = '0;
               fall_cnt_n = '0;
            end
         end
         PLAY: begin
            if (collision) begin
               state_n = OVER;
            end else begin
               // A press overrides a fall that is due in the same cycle
               if (press) begin
                  flap_n     = 1'b1;
                  fall_cnt_n = '0;
               end else if (tick) begin
                  if (fall_cnt == CNT_LAST) begin
                     fall_n     = 1'b1;
                     fall_cnt_n = '0;
                  end else begin
                     fall_cnt_n = fall_cnt + CNT_W'(1);
                  end
               end
               if (pipe_pass && (score != SCORE_MAX)) begin
                  score_n = score + SCORE_W'(1);
               end
            end
         end
         OVER: begin
            if (press) begin
               state_n   = IDLE;
               restart_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bird_game_ctrl.sv
// Directed scoreboard bench for bird_game_ctrl: the driver queues expected outputs,
// a negedge monitor pops and compares them against the registered outputs.
module tb_bird_game_ctrl;

   logic       clk = 1'b0;
   logic       reset, key, tick, pipe_pass;
   logic [7:0] bird_rows, pipe_rows;
   logic       flap, fall, restart, playing, game_over;
   logic [3:0] score;

   typedef struct packed {
      logic       flap;
      logic       fall;
      logic       restart;
      logic       playing;
      logic       game_over;
      logic [3:0] score;
   } exp_t;

   typedef struct {
      string name;
      exp_t  val;
   } sb_t;

   sb_t q[$];
   int  checks = 0;
   int  errors = 0;

   bird_game_ctrl #(.ROWS(8), .FALL_TICKS(4), .SCORE_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .key       (key),
      .tick      (tick),
      .bird_rows (bird_rows),
      .pipe_rows (pipe_rows),
      .pipe_pass (pipe_pass),
      .flap      (flap),
      .fall      (fall),
      .restart   (restart),
      .playing   (playing),
      .game_over (game_over),
      .score     (score)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are registered, so compare away from the active edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         sb_t  e;
         exp_t act;
         e   = q.pop_front();
         act = '{flap, fall, restart, playing, game_over, score};
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got flap=%b fall=%b restart=%b playing=%b game_over=%b score=%0d, want flap=%b fall=%b restart=%b playing=%b game_over=%b score=%0d",
                     e.name, act.flap, act.fall, act.restart, act.playing, act.game_over, act.score,
                     e.val.flap, e.val.fall, e.val.restart, e.val.playing, e.val.game_over, e.val.score);
         end
      end
   end

   // One clock of stimulus; the expected outputs after that edge are queued
   task automatic step(input string name, input logic r, input logic k, input logic t,
                       input logic pp, input logic e_flap, input logic e_fall,
                       input logic e_rst, input logic e_play, input logic e_over,
                       input logic [3:0] e_score);
      sb_t e;
      reset     = r;
      key       = k;
      tick      = t;
      pipe_pass = pp;
      @(posedge clk);
      e.name = name;
      e.val  = '{e_flap, e_fall, e_rst, e_play, e_over, e_score};
      q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      bird_rows = 8'h01;
      pipe_rows = 8'h00;

      // Key held through reset and afterwards is not a press
      step("rst_hold0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      step("rst_hold1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      for (int i = 0; i < 3; i++) step("key_held_idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);

      // Start the game: no flap for the starting press, then a fall after 4 ticks
      step("key_low_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      step("start_press",  0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      step("start_held",   0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      step("start_rel",    0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      for (int i = 0; i < 3; i++) step("tick_no_fall", 0, 0, 1, 0, 0, 0, 0, 1, 0, 4'd0);
      step("tick4_fall",     0, 0, 1, 0, 0, 1, 0, 1, 0, 4'd0);
      step("fall_one_cycle", 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);

      // Press wins over a due fall and restarts the fall count
      for (int i = 0; i < 3; i++) step("pre_tick", 0, 0, 1, 0, 0, 0, 0, 1, 0, 4'd0);
      step("press_beats_fall", 0, 1, 1, 0, 1, 0, 0, 1, 0, 4'd0);
      step("flap_one_cycle",   0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      for (int i = 0; i < 3; i++) step("post_flap_tick", 0, 0, 1, 0, 0, 0, 0, 1, 0, 4'd0);
      step("post_flap_fall",   0, 0, 1, 0, 0, 1, 0, 1, 0, 4'd0);
      step("post_flap_idle",   0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);

      for (int i = 1; i <= 5; i++) step("score_inc", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'(i));

      // Overlap collision: press, tick and pipe_pass are all suppressed
      bird_rows = 8'h10; pipe_rows = 8'h10;
      step("collide_over", 0, 1, 1, 1, 0, 0, 0, 0, 1, 4'd5);
      bird_rows = 8'h01; pipe_rows = 8'h00;
      step("over_hold_a", 0, 1, 1, 1, 0, 0, 0, 0, 1, 4'd5);
      step("over_hold_b", 0, 0, 1, 1, 0, 0, 0, 0, 1, 4'd5);
      step("over_restart",   0, 1, 0, 0, 0, 0, 1, 0, 0, 4'd5);
      step("restart_1cycle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd5);
      step("replay_clear",   0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      step("replay_rel",     0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);

      // Empty bird column is also game over
      bird_rows = 8'h00;
      step("empty_over", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
      bird_rows = 8'h01;
      step("empty_restart", 0, 1, 0, 0, 0, 0, 1, 0, 0, 4'd0);
      step("empty_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      step("play2",         0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      step("play2_rel",     0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);

      // Score saturates at 15
      for (int i = 1; i <= 17; i++)
         step("score_sat", 0, 0, 0, 1, 0, 0, 0, 1, 0, (i > 15) ? 4'd15 : 4'(i));
      bird_rows = 8'h10; pipe_rows = 8'h10;
      step("sat_collide", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd15);
      bird_rows = 8'h01; pipe_rows = 8'h00;
      step("sat_restart",  0, 1, 0, 0, 0, 0, 1, 0, 0, 4'd15);
      step("sat_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd15);
      step("sat_newgame",  0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      step("sat_rel",      0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);

      // Mid-play reset discards the pending fall and the score
      step("pre_rst_pass", 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'd1);
      step("pre_rst_t1",   0, 0, 1, 0, 0, 0, 0, 1, 0, 4'd1);
      step("pre_rst_t2",   0, 0, 1, 0, 0, 0, 0, 1, 0, 4'd1);
      step("mid_reset",    1, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0);
      step("post_reset",   0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0);

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
